mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding HI/LO.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] mt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rsraw_q, rsraw_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        in_sgn;
  logic        op_sgn;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] msum;
  logic [32:0] rshift;
  logic [32:0] trial;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  assign in_sgn = ~op[0];
  assign op_sgn = ~op_q[0];
  assign mag_a  = (in_sgn && rs_data[31]) ? -rs_data : rs_data;
  assign mag_b  = (in_sgn && rt_data[31]) ? -rt_data : rt_data;

  // Multiply: add multiplicand into the upper half, shift right.
  assign msum   = {1'b0, acc_q[63:32]}
                + (acc_q[0] ? {1'b0, a_q} : 33'd0);
  // Divide: acc_q[31:0] shifts dividend out and quotient in.
  assign rshift = {1'b0, rem_q, acc_q[31]} >> 0;
  assign trial  = rshift - {1'b0, b_q};

  assign prod = (op_sgn && (sa_q ^ sb_q)) ? -acc_q : acc_q;
  assign quo  = (op_sgn && (sa_q ^ sb_q)) ? -acc_q[31:0] : acc_q[31:0];
  assign rem  = (op_sgn && sa_q) ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    rsraw_d = rsraw_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          sa_d    = in_sgn & rs_data[31];
          sb_d    = in_sgn & rt_data[31];
          a_d     = mag_a;
          b_d     = mag_b;
          rsraw_d = rs_data;
          cnt_d   = 6'd0;
          rem_d   = 32'd0;
          acc_d   = op[1] ? {32'd0, mag_a}
                          : {32'd0, mag_b};
          state_d = RUN;
        end else begin
          if (hi_we) hi_d = mt_data;
          if (lo_we) lo_d = mt_data;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (!op_q[1]) begin
          acc_d = {msum, acc_q[31:1]};
        end else if (!trial[32]) begin
          rem_d = trial[31:0];
          acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
        end else begin
          rem_d = rshift[31:0];
          acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
        end
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (!op_q[1]) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else if (b_q == 32'd0) begin
          hi_d = rsraw_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rsraw_q <= 32'd0;
      acc_q   <= 64'd0;
      rem_q   <= 32'd0;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rsraw_q <= rsraw_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
